// File: rtl/pad_mux_cfg.sv
// pad_mux_cfg: APB register block holding per-pad mux selections.
// Software fills SHADOW registers and commits them atomically. Each commit runs a quiet window
// that forces pad output enables low while the pad functions change.
// A sticky LOCK bit freezes the configuration until reset.
module pad_mux_cfg #(
  parameter int unsigned N_IO           = 64,
  parameter int unsigned NBIT_PADMUX    = 2,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [APB_ADDR_WIDTH-1:0]        PADDR,
  input  logic [31:0]                      PWDATA,
  input  logic                             PWRITE,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  output logic [31:0]                      PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  output logic [N_IO-1:0][NBIT_PADMUX-1:0] pad_mux_o,
  output logic                             pad_quiet_o
);

  localparam int unsigned WordW = APB_ADDR_WIDTH - 2;
  localparam int unsigned IdxW  = (N_IO > 1) ? $clog2(N_IO) : 1;

  localparam logic [WordW-1:0] CtrlWord   = WordW'(32'h100);
  localparam logic [WordW-1:0] StatusWord = WordW'(32'h101);
  localparam logic [WordW-1:0] QuietWord  = WordW'(32'h102);

  typedef enum logic [1:0] {StIdle, StQuiet, StApply, StSettle} state_e;

  // Registered state
  logic [N_IO-1:0][NBIT_PADMUX-1:0] r_shadow;
  logic [N_IO-1:0][NBIT_PADMUX-1:0] r_pad_mux;
  logic [7:0]                       r_quiet_cycles;
  logic                             r_lock;
  state_e                           r_state;
  logic [7:0]                       r_cnt;
  logic                             r_pad_quiet;

  // Decode and next-state signals
  logic [WordW-1:0] w_word;
  logic [IdxW-1:0]  w_idx;
  logic             w_access;
  logic             w_wr;
  logic             w_is_shadow;
  logic             w_is_ctrl;
  logic             w_is_status;
  logic             w_is_quiet;
  logic             w_valid;
  logic             w_busy;
  logic             w_commit_req;
  logic             w_commit;
  logic             w_lock_set;
  logic             w_shadow_we;
  logic             w_quiet_we;
  logic             w_lock_err;
  logic             w_busy_err;
  state_e           w_state_d;
  logic [7:0]       w_cnt_d;
  logic             w_quiet_d;

  // Byte-lane bits of the address and unused write-data bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:8]};

  assign w_word      = PADDR[APB_ADDR_WIDTH-1:2];
  assign w_idx       = w_word[IdxW-1:0];
  assign w_access    = PSEL & PENABLE;
  assign w_wr        = w_access & PWRITE;
  assign w_is_shadow = (32'(w_word) < N_IO);
  assign w_is_ctrl   = (w_word == CtrlWord);
  assign w_is_status = (w_word == StatusWord);
  assign w_is_quiet  = (w_word == QuietWord);
  assign w_valid     = w_is_shadow | w_is_ctrl | w_is_status | w_is_quiet;
  assign w_busy      = (r_state != StIdle);

  assign w_commit_req = w_wr & w_is_ctrl & PWDATA[0];
  assign w_commit     = w_commit_req & ~r_lock & ~w_busy;
  assign w_lock_set   = w_wr & w_is_ctrl & PWDATA[1];
  assign w_shadow_we  = w_wr & w_is_shadow & ~r_lock;
  assign w_quiet_we   = w_wr & w_is_quiet & ~r_lock;

  assign w_lock_err = r_lock & ((w_wr & (w_is_shadow | w_is_quiet)) | w_commit_req);
  assign w_busy_err = w_commit_req & w_busy;

  assign PREADY      = 1'b1;
  assign pad_mux_o   = r_pad_mux;
  assign pad_quiet_o = r_pad_quiet;

  // Error flag: bad address, write to read-only STATUS, locked write, or commit while busy
  always_comb begin
    PSLVERR = 1'b0;
    if (w_access) begin
      PSLVERR = ~w_valid | (w_wr & w_is_status) | w_lock_err | w_busy_err;
    end
  end

  // Read data mux, driven only during a read access phase
  always_comb begin
    PRDATA = 32'h0;
    if (w_access && !PWRITE) begin
      if (w_is_shadow) begin
        PRDATA = 32'(r_shadow[w_idx]);
      end else if (w_is_ctrl) begin
        PRDATA = {30'h0, r_lock, 1'b0};
      end else if (w_is_status) begin
        PRDATA = {30'h0, r_lock, w_busy};
      end else if (w_is_quiet) begin
        PRDATA = {24'h0, r_quiet_cycles};
      end
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shadow       <= '0;
      r_quiet_cycles <= 8'd4;
      r_lock         <= 1'b0;
    end else begin
      if (w_shadow_we) begin
        r_shadow[w_idx] <= PWDATA[NBIT_PADMUX-1:0];
      end
      if (w_quiet_we) begin
        r_quiet_cycles <= PWDATA[7:0];
      end
      if (w_lock_set) begin
        r_lock <= 1'b1;
      end
    end
  end

  // Commit FSM state register, quiet counter and registered quiet flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_pad_quiet <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_pad_quiet <= w_quiet_d;
    end
  end

  // Commit FSM next state and counter
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_commit) begin
          if (r_quiet_cycles != 8'd0) begin
            w_state_d = StQuiet;
            w_cnt_d   = r_quiet_cycles;
          end else begin
            w_state_d = StApply;
          end
        end
      end
      StQuiet: begin
        w_cnt_d = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_d = StApply;
        end
      end
      StApply:  w_state_d = StSettle;
      StSettle: w_state_d = StIdle;
    endcase
  end

  // Quiet flag looks at the next state so it rises on the cycle right after the commit edge
  always_comb begin
    w_quiet_d = (w_state_d != StIdle);
  end

  // Active mux selection: all pads take the shadow values together on the edge leaving APPLY
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pad_mux <= '0;
    end else if (r_state == StApply) begin
      r_pad_mux <= r_shadow;
    end
  end

endmodule

// File: tb/tb_pad_mux_cfg.sv
// Bench for pad_mux_cfg: cycle-level reference model plus directed APB sequences.
module tb_pad_mux_cfg;

  localparam int N_IO = 64;
  localparam int NB   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [11:0]             paddr;
  logic [31:0]             pwdata;
  logic [31:0]             prdata;
  logic                    pwrite, psel, penable;
  logic                    pready, pslverr;
  logic [N_IO-1:0][NB-1:0] pad_mux;
  logic                    pad_quiet;

  pad_mux_cfg #(
    .N_IO          (N_IO),
    .NBIT_PADMUX   (NB),
    .APB_ADDR_WIDTH(12)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .PADDR      (paddr),
    .PWDATA     (pwdata),
    .PWRITE     (pwrite),
    .PSEL       (psel),
    .PENABLE    (penable),
    .PRDATA     (prdata),
    .PREADY     (pready),
    .PSLVERR    (pslverr),
    .pad_mux_o  (pad_mux),
    .pad_quiet_o(pad_quiet)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: commit accepted at edge E with quiet count Q keeps the block busy
  // (and pad_quiet high) after edges E..E+Q+1; the mux takes SHADOW at edge E+Q+1.
  int                      cyc = 0;
  logic [N_IO-1:0][NB-1:0] m_shadow, m_mux;
  logic [7:0]              m_q;
  bit                      m_lock;
  int                      m_e  = -100;
  int                      m_q0 = 0;

  function automatic bit win(input int c);
    return (c >= m_e) && (c <= m_e + m_q0 + 1);
  endfunction

  task automatic model_step();
    int  a;
    bit  busy;
    cyc++;
    if (rst) begin
      m_shadow = '0; m_mux = '0; m_q = 8'd4; m_lock = 0; m_e = -100; m_q0 = 0;
      return;
    end
    busy = win(cyc - 1);
    if (cyc == m_e + m_q0 + 1) m_mux = m_shadow;
    if (psel && penable && pwrite) begin
      a = int'(paddr[11:2]);
      if (a < N_IO) begin
        if (!m_lock) m_shadow[a] = pwdata[NB-1:0];
      end else if (a == 258) begin
        if (!m_lock) m_q = pwdata[7:0];
      end else if (a == 256) begin
        if (pwdata[0] && !m_lock && !busy) begin
          m_e  = cyc;
          m_q0 = int'(m_q);
        end
        if (pwdata[1]) m_lock = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [32:0] exp_apb();  // {pslverr, prdata}
    int   a;
    bit   busy, valid, err;
    logic [31:0] rd;
    if (!(psel && penable)) return 33'h0;
    a     = int'(paddr[11:2]);
    busy  = win(cyc);
    valid = (a < N_IO) || (a == 256) || (a == 257) || (a == 258);
    err   = !valid;
    rd    = 32'h0;
    if (pwrite) begin
      if (a == 257) err = 1;
      if (m_lock && ((a < N_IO) || (a == 258) || (a == 256 && pwdata[0]))) err = 1;
      if (a == 256 && pwdata[0] && busy) err = 1;
    end else begin
      if (a < N_IO)      rd = 32'(m_shadow[a]);
      else if (a == 256) rd = {30'h0, m_lock, 1'b0};
      else if (a == 257) rd = {30'h0, m_lock, busy};
      else if (a == 258) rd = {24'h0, m_q};
    end
    return {err, rd};
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (cmp_en) begin
      e = exp_apb();
      check("pad_mux_o", pad_mux, m_mux);
      check("pad_quiet_o", 128'(pad_quiet), 128'(win(cyc)));
      check("PREADY", 128'(pready), 128'(1'b1));
      check("PRDATA", 128'(prdata), 128'(e[31:0]));
      check("PSLVERR", 128'(pslverr), 128'(e[32]));
    end
  end

  task automatic xfer(input logic w, input logic [11:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic err);
    psel = 1; penable = 0; pwrite = w; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic count_quiet(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (pad_quiet) c++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          c;
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    @(posedge clk); #1;
    cmp_en = 1;
    @(posedge clk); #1;
    rst = 0;

    // Reset values
    xfer(0, 12'h000, 0, rd, err); check("rst_shadow0", 128'(rd), 0); check("rst_shadow0_err", 128'(err), 0);
    xfer(0, 12'h400, 0, rd, err); check("rst_ctrl", 128'(rd), 0);
    xfer(0, 12'h404, 0, rd, err); check("rst_status", 128'(rd), 0);
    xfer(0, 12'h408, 0, rd, err); check("rst_quiet", 128'(rd), 4);
    check("rst_pad_mux", pad_mux, 0);
    check("rst_pad_quiet", 128'(pad_quiet), 0);

    // Commit with Q=4: six quiet cycles, mux updated
    xfer(1, 12'h014, 2, rd, err);
    xfer(1, 12'h0FC, 3, rd, err);
    xfer(1, 12'h400, 1, rd, err); check("commit_err", 128'(err), 0);
    count_quiet(10, c); check("q4_quiet_len", 128'(c), 6);
    check("q4_mux5", 128'(pad_mux[5]), 2);
    check("q4_mux63", 128'(pad_mux[63]), 3);
    check("q4_mux0", 128'(pad_mux[0]), 0);

    // Q=0: quiet for two cycles, mux changes on the second
    xfer(1, 12'h408, 0, rd, err);
    xfer(1, 12'h000, 1, rd, err);
    xfer(1, 12'h400, 1, rd, err);
    @(negedge clk); check("q0_c1_quiet", 128'(pad_quiet), 1); check("q0_c1_mux0", 128'(pad_mux[0]), 0);
    @(posedge clk); #1;
    @(negedge clk); check("q0_c2_quiet", 128'(pad_quiet), 1); check("q0_c2_mux0", 128'(pad_mux[0]), 1);
    @(posedge clk); #1;
    @(negedge clk); check("q0_c3_quiet", 128'(pad_quiet), 0);
    @(posedge clk); #1;

    // Q=5: busy status, rejected second commit, SHADOW write on the APPLY edge
    xfer(1, 12'h408, 5, rd, err);
    xfer(1, 12'h400, 1, rd, err);
    xfer(0, 12'h404, 0, rd, err); check("busy_status", 128'(rd), 1);
    xfer(1, 12'h400, 1, rd, err); check("busy_commit_err", 128'(err), 1);
    xfer(1, 12'h004, 1, rd, err); check("apply_edge_wr_err", 128'(err), 0);
    idle(3);
    check("apply_edge_mux1", 128'(pad_mux[1]), 0);
    check("apply_edge_quiet", 128'(pad_quiet), 0);
    xfer(0, 12'h004, 0, rd, err); check("apply_edge_shadow1", 128'(rd), 1);

    // Commit plus lock in one write
    xfer(1, 12'h400, 3, rd, err); check("commit_lock_err", 128'(err), 0);
    idle(10);
    xfer(0, 12'h404, 0, rd, err); check("locked_status", 128'(rd), 2);
    check("locked_mux1", 128'(pad_mux[1]), 1);
    xfer(1, 12'h004, 0, rd, err); check("locked_shadow_wr_err", 128'(err), 1);
    xfer(0, 12'h004, 0, rd, err); check("locked_shadow_rd", 128'(rd), 1); check("locked_rd_err", 128'(err), 0);
    xfer(1, 12'h408, 7, rd, err); check("locked_quiet_wr_err", 128'(err), 1);
    xfer(0, 12'h408, 0, rd, err); check("locked_quiet_rd", 128'(rd), 5);
    xfer(1, 12'h400, 1, rd, err); check("locked_commit_err", 128'(err), 1);
    idle(2); check("locked_no_quiet", 128'(pad_quiet), 0);
    xfer(0, 12'h400, 0, rd, err); check("locked_ctrl_rd", 128'(rd), 2);

    // Reset clears lock
    rst = 1; idle(1); rst = 0;
    xfer(0, 12'h404, 0, rd, err); check("unlock_status", 128'(rd), 0);

    // Illegal addresses and STATUS write
    xfer(0, 12'h40C, 0, rd, err); check("bad40c_rd", 128'(rd), 0); check("bad40c_err", 128'(err), 1);
    xfer(1, 12'h40C, 32'hFF, rd, err); check("bad40c_wr_err", 128'(err), 1);
    xfer(0, 12'h100, 0, rd, err); check("bad100_rd", 128'(rd), 0); check("bad100_err", 128'(err), 1);
    xfer(1, 12'h100, 3, rd, err); check("bad100_wr_err", 128'(err), 1);
    xfer(1, 12'h404, 3, rd, err); check("status_wr_err", 128'(err), 1);

    // Reset during QUIET
    xfer(1, 12'h008, 3, rd, err);
    xfer(1, 12'h400, 1, rd, err);
    idle(8);
    check("pre_rst_mux2", 128'(pad_mux[2]), 3);
    xfer(1, 12'h400, 1, rd, err);
    idle(2);
    check("pre_rst_quiet", 128'(pad_quiet), 1);
    rst = 1;
    @(posedge clk); #1;
    check("rst_quiet_low", 128'(pad_quiet), 0);
    check("rst_mux_zero", pad_mux, 0);
    rst = 0;
    xfer(0, 12'h404, 0, rd, err); check("rst_idle_status", 128'(rd), 0);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
